bayer_window_buffer: RTL and testbench
======================================

Name: bayer_window_buffer

Overview:
- Upstream of the demosaic stage. Turns a raster-ordered 8-bit Bayer pixel stream into a 6x6 mosaic window and the 2-bit center pixel type.
- Output port shapes match the demosaic input exactly: pixel_mosaic_matrix[0:5][0:5] with the center at [2][2], plus center_pixel_type.
- Built from 5 line memories and a 6-column shift window. Emits one window per interior pixel.

Parameters:
- WIDTH, 640, active pixels per line; must be >= 6.
- HEIGHT, 480, active lines per frame; must be >= 6.
- X_PHASE, 0, column-parity offset of the CFA. 0 = BGGR/GRBG-style column alignment.
- Y_PHASE, 0, row-parity offset of the CFA. 0 = blue/green row first.

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_of_frame  input  1  pulse; the beat it qualifies (or the next valid beat) is pixel (0,0).
- pixel_valid  input  1  input beat qualifier. No backpressure exists.
- pixel_data  input  8  raw Bayer sample.
- window_valid  output  1  window outputs are valid this cycle.
- pixel_mosaic_matrix  output  8 x [0:5][0:5]  window. [r][c] = pixel (cx-2+c, cy-2+r).
- center_pixel_type  output  2  encoding: 0 Blue, 1 Green in blue row, 2 Green in red row, 3 Red.

Behaviour:
- Reset (synchronous, active-high): clears the input counters in_x/in_y, window_valid=0, pixel_mosaic_matrix all 0, center_pixel_type=0. Line-memory contents are not cleared.
- Input counting:
  - On pixel_valid, the beat is at (in_x, in_y); in_x increments.
  - At in_x==WIDTH-1, in_x wraps to 0 and in_y increments.
  - After (WIDTH-1, HEIGHT-1), further beats are ignored (no writes, no windows) until start_of_frame.
  - start_of_frame forces in_x=in_y=0. If it coincides with pixel_valid, that beat is (0,0).
  - start_of_frame mid-frame abandons the partial frame without error.
- Line storage:
  - 5 line memories of WIDTH x 8, organised as a rotating ring indexed by in_y mod 5.
  - Each beat reads column in_x from all 5 memories (rows in_y-5..in_y-1) and writes pixel_data to row in_y.
  - Read-before-write to the same address is required.
  - The 6-entry column {5 stored rows, live pixel} is rotated into row order and shifted into the 6x6 register window: column 5 is the newest, column 0 the oldest.
- Window emission:
  - A window for center (cx,cy) = (in_x-3, in_y-3) is emitted when in_x>=5 and in_y>=5.
  - window_valid rises exactly 1 cycle after that input beat (registered outputs) and lasts 1 cycle per qualifying beat.
  - Centers cover cx in 2..WIDTH-4 and cy in 2..HEIGHT-4. Border pixels get no output.
  - Count per frame is (WIDTH-5)*(HEIGHT-5).
- The window shift register advances only on pixel_valid. Gaps in pixel_valid do not disturb alignment.
- center_pixel_type = {cy[0]^Y_PHASE, cx[0]^X_PHASE}, registered with the window.
- Matrix contents are undefined when window_valid=0, but they hold their last value (no update without pixel_valid).
- Reset mid-frame:
  - Outputs drop the next cycle.
  - The next beat is treated as (0,0). Stale line-memory data is never emitted, because windows require 5 fresh rows.

Optional Feature:
- Macro: BAYER_WINDOW_POSITION_EN.
- When defined:
  - Adds outputs center_x [$clog2(WIDTH)-1:0] and center_y [$clog2(HEIGHT)-1:0].
  - Both are registered alongside window_valid, equal to (cx,cy), and reset to 0.
- When undefined: the ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Shared package bayer_pkg holds:
  - typedef pixel_t (logic [7:0]);
  - typedef bayer_type_t enum {BAYER_BLUE=0, BAYER_GREEN_BLUE_ROW=1, BAYER_GREEN_RED_ROW=2, BAYER_RED=3};
  - constant WINDOW_SIZE=6;
  - constant CENTER_OFFSET=2.
- One sub-module, bayer_line_memory: single-clock WIDTH x 8 RAM with a read-before-write port. It is instantiated 5 times.

Test Plan (WIDTH=8, HEIGHT=8, pixel_data=8*y+x, phases 0):
- Continuous frame -> exactly 9 window_valid pulses. The first pulse is 1 cycle after beat (5,5), with matrix[r][c]=8*r+c (matrix[2][2]=18) and center_pixel_type=0.
- Check windows 2 and 4 of the same frame -> center (3,2) gives type 1 and matrix[2][2]=19; center (2,3) gives type 2 and matrix[2][2]=26. Center (3,3) gives type 3.
- Random 1-3 cycle gaps in pixel_valid -> identical window sequence and values as the continuous case.
- X_PHASE=1, Y_PHASE=1 -> first window type 3. Extra beats after (7,7) without start_of_frame -> no window_valid.
- Reset asserted at beat (4,6) of frame 1, then a fresh frame with values +100 -> no window until beat (5,5) of the new frame, and that window has matrix[0][0]=100. Outputs read 0 during reset.
- start_of_frame at beat (3,4), coincident with pixel_valid -> that beat is (0,0). The 9 windows that follow match a clean frame.

Source files
------------

// File: rtl/bayer_window_buffer_pkg.sv
// Shared types and constants for the Bayer window buffer: pixel type, CFA
// colour encoding, window geometry and the line-ring index helper.
package bayer_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    BAYER_BLUE           = 2'd0,
    BAYER_GREEN_BLUE_ROW = 2'd1,
    BAYER_GREEN_RED_ROW  = 2'd2,
    BAYER_RED            = 2'd3
  } bayer_type_t;

  localparam int WINDOW_SIZE   = 6;
  localparam int CENTER_OFFSET = 2;
  localparam int NUM_LINES     = WINDOW_SIZE - 1;

  // (base + offset) mod NUM_LINES for ring positions that are already < NUM_LINES.
  function automatic logic [2:0] ring_index(input logic [2:0] base, input logic [2:0] offset);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= 4'(NUM_LINES)) begin
      return 3'(sum - 4'(NUM_LINES));
    end else begin
      return sum[2:0];
    end
  endfunction

  function automatic bayer_type_t center_type(input logic y_odd, input logic x_odd);
    return bayer_type_t'({y_odd, x_odd});
  endfunction

endpackage

// File: rtl/bayer_window_buffer_line_memory.sv
// One line of Bayer pixels: single-clock RAM whose combinational read returns
// the word stored before a same-cycle write to the same address.
module bayer_line_memory
  import bayer_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          write_enable,
  input  logic [AW-1:0] addr,
  input  pixel_t        write_data,
  output pixel_t        read_data
);

  pixel_t mem [0:DEPTH-1];

  assign read_data = mem[addr];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[addr] <= write_data;
    end
  end

endmodule

// File: rtl/bayer_window_buffer.sv
// Raster Bayer stream to 6x6 mosaic window with center CFA type.
// Optional BAYER_WINDOW_POSITION_EN adds registered center_x/center_y outputs.
module bayer_window_buffer
  import bayer_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int X_PHASE = 0,
  parameter int Y_PHASE = 0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        start_of_frame,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_data,
  output logic        window_valid,
  output pixel_t      pixel_mosaic_matrix [0:WINDOW_SIZE-1][0:WINDOW_SIZE-1],
  output logic [1:0]  center_pixel_type
`ifdef BAYER_WINDOW_POSITION_EN
  ,
  output logic [$clog2(WIDTH)-1:0]  center_x,
  output logic [$clog2(HEIGHT)-1:0] center_y
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_FIRST  = XW'(WINDOW_SIZE - 1);
  localparam logic [YW-1:0] Y_FIRST  = YW'(WINDOW_SIZE - 1);
  localparam int            LAG      = WINDOW_SIZE - 1 - CENTER_OFFSET;
  localparam logic          X_PH     = 1'(X_PHASE);
  localparam logic          Y_PH     = 1'(Y_PHASE);

  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [2:0]    in_slot;
  logic          frame_done;

  logic [XW-1:0] beat_x;
  logic [YW-1:0] beat_y;
  logic [2:0]    beat_slot;
  logic          beat_accept;
  logic          beat_emit;
  logic          line_end;
  logic          frame_end;

  pixel_t line_rd [0:NUM_LINES-1];
  pixel_t column  [0:WINDOW_SIZE-1];

  // start_of_frame redirects the beat it qualifies to (0,0).
  always_comb begin
    beat_x    = in_x;
    beat_y    = in_y;
    beat_slot = in_slot;
    if (start_of_frame) begin
      beat_x    = '0;
      beat_y    = '0;
      beat_slot = 3'd0;
    end else begin
      beat_x    = in_x;
      beat_y    = in_y;
      beat_slot = in_slot;
    end
    beat_accept = pixel_valid && (start_of_frame || !frame_done);
    beat_emit   = beat_accept && (beat_x >= X_FIRST) && (beat_y >= Y_FIRST);
    line_end    = (beat_x == X_LAST);
    frame_end   = line_end && (beat_y == Y_LAST);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      in_x       <= '0;
      in_y       <= '0;
      in_slot    <= 3'd0;
      frame_done <= 1'b0;
    end else if (beat_accept) begin
      if (frame_end) begin
        in_x       <= '0;
        in_y       <= '0;
        in_slot    <= 3'd0;
        frame_done <= 1'b1;
      end else if (line_end) begin
        in_x       <= '0;
        in_y       <= beat_y + YW'(1);
        in_slot    <= ring_index(beat_slot, 3'd1);
        frame_done <= 1'b0;
      end else begin
        in_x       <= beat_x + XW'(1);
        in_y       <= beat_y;
        in_slot    <= beat_slot;
        frame_done <= 1'b0;
      end
    end else if (start_of_frame) begin
      in_x       <= '0;
      in_y       <= '0;
      in_slot    <= 3'd0;
      frame_done <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    bayer_line_memory #(
      .DEPTH (WIDTH),
      .AW    (XW)
    ) u_mem (
      .clk          (clk_pixel),
      .write_enable (beat_accept && (beat_slot == 3'(k))),
      .addr         (beat_x),
      .write_data   (pixel_data),
      .read_data    (line_rd[k])
    );
  end

  // Slot beat_slot still holds row y-5 (read before write); later slots follow in row order.
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      column[i] = line_rd[ring_index(beat_slot, 3'(i))];
    end
    column[WINDOW_SIZE-1] = pixel_data;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      window_valid      <= 1'b0;
      center_pixel_type <= 2'd0;
      for (int r = 0; r < WINDOW_SIZE; r++) begin
        for (int c = 0; c < WINDOW_SIZE; c++) begin
          pixel_mosaic_matrix[r][c] <= 8'd0;
        end
      end
    end else begin
      window_valid <= beat_emit;
      // Center sits 3 columns/rows behind the beat, so its parity is the beat's inverted.
      if (beat_emit) begin
        center_pixel_type <= center_type(~beat_y[0] ^ Y_PH, ~beat_x[0] ^ X_PH);
      end
      if (beat_accept) begin
        for (int r = 0; r < WINDOW_SIZE; r++) begin
          for (int c = 0; c < WINDOW_SIZE - 1; c++) begin
            pixel_mosaic_matrix[r][c] <= pixel_mosaic_matrix[r][c+1];
          end
          pixel_mosaic_matrix[r][WINDOW_SIZE-1] <= column[r];
        end
      end
    end
  end

`ifdef BAYER_WINDOW_POSITION_EN
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      center_x <= '0;
      center_y <= '0;
    end else if (beat_emit) begin
      center_x <= beat_x - XW'(LAG);
      center_y <= beat_y - YW'(LAG);
    end
  end
`endif

endmodule

// File: tb/tb_bayer_window_buffer.sv
// Scoreboard bench for bayer_window_buffer at 8x8: phase-0 and phase-1 instances
// share one stimulus stream; expected windows are queued as beats are driven.
module tb_bayer_window_buffer;
  import bayer_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start_of_frame = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] pixel_data = 8'd0;

  logic       wv0, wv1;
  pixel_t     m0 [0:5][0:5];
  pixel_t     m1 [0:5][0:5];
  logic [1:0] t0, t1;
`ifdef BAYER_WINDOW_POSITION_EN
  logic [2:0] cx0, cy0, cx1, cy1;
`endif

  bayer_window_buffer #(.WIDTH(W), .HEIGHT(H), .X_PHASE(0), .Y_PHASE(0)) dut (
    .clk_pixel           (clk),
    .reset               (reset),
    .start_of_frame      (start_of_frame),
    .pixel_valid         (pixel_valid),
    .pixel_data          (pixel_data),
    .window_valid        (wv0),
    .pixel_mosaic_matrix (m0),
    .center_pixel_type   (t0)
`ifdef BAYER_WINDOW_POSITION_EN
    ,
    .center_x            (cx0),
    .center_y            (cy0)
`endif
  );

  bayer_window_buffer #(.WIDTH(W), .HEIGHT(H), .X_PHASE(1), .Y_PHASE(1)) dut_phase (
    .clk_pixel           (clk),
    .reset               (reset),
    .start_of_frame      (start_of_frame),
    .pixel_valid         (pixel_valid),
    .pixel_data          (pixel_data),
    .window_valid        (wv1),
    .pixel_mosaic_matrix (m1),
    .center_pixel_type   (t1)
`ifdef BAYER_WINDOW_POSITION_EN
    ,
    .center_x            (cx1),
    .center_y            (cy1)
`endif
  );

  typedef struct {
    int cx;
    int cy;
    int base;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur;
  int   checks = 0;
  int   passed = 0;
  int   frame_windows = 0;
  logic emit_drv = 1'b0;
  logic emit_cap = 1'b0;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pix(input int base, input int x, input int y);
    return (base + 8 * y + x) & 255;
  endfunction

  function automatic int nonzero_cells();
    int n = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        if (m0[r][c] != 8'd0) n++;
    return n;
  endfunction

  // Reference: a window is due one cycle after an accepted interior beat.
  always @(posedge clk) emit_cap <= emit_drv && pixel_valid && !reset;

  always @(negedge clk) begin
    if (wv0 || emit_cap) check_value("window_valid", int'(wv0), int'(emit_cap));
    if (wv1 || emit_cap) check_value("phase_window_valid", int'(wv1), int'(emit_cap));
    if (wv0) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_window", 1, 0);
      end else begin
        int errs;
        cur = exp_q.pop_front();
        errs = 0;
        for (int r = 0; r < 6; r++)
          for (int c = 0; c < 6; c++)
            if (int'(m0[r][c]) != pix(cur.base, cur.cx - 2 + c, cur.cy - 2 + r)) errs++;
        check_value("matrix_errors", errs, 0);
        check_value("m22", int'(m0[2][2]), pix(cur.base, cur.cx, cur.cy));
        check_value("type", int'(t0), (cur.cy % 2) * 2 + (cur.cx % 2));
        if (wv1) begin
          check_value("phase_type", int'(t1), (1 - cur.cy % 2) * 2 + (1 - cur.cx % 2));
          check_value("phase_m22", int'(m1[2][2]), pix(cur.base, cur.cx, cur.cy));
        end
        frame_windows++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int base, input bit sof, input int nbeats, input int max_gap);
    int x;
    int y;
    for (int i = 0; i < nbeats; i++) begin
      x = i % W;
      y = i / W;
      start_of_frame = sof && (i == 0);
      pixel_valid    = 1'b1;
      pixel_data     = 8'(pix(base, x, y));
      emit_drv       = (x >= 5) && (y >= 5);
      if (emit_drv) exp_q.push_back('{x - 3, y - 3, base});
      @(posedge clk);
      #1;
      start_of_frame = 1'b0;
      pixel_valid    = 1'b0;
      emit_drv       = 1'b0;
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 1)));
    end
  endtask

  initial begin
    idle(2);
    check_value("reset_valid", int'(wv0), 0);
    check_value("reset_matrix_nonzero", nonzero_cells(), 0);
    check_value("reset_type", int'(t0), 0);
    reset = 1'b0;
    idle(2);

    // Continuous frame
    frame_windows = 0;
    drive_frame(0, 1'b1, W * H, 0);
    idle(3);
    check_value("count_continuous", frame_windows, 9);

    // Beats after the last pixel without start_of_frame are ignored
    for (int i = 0; i < 5; i++) begin
      pixel_valid = 1'b1;
      pixel_data  = 8'(200 + i);
      @(posedge clk);
      #1;
    end
    pixel_valid = 1'b0;
    idle(3);
    check_value("count_after_end", frame_windows, 9);

    // Random gaps in pixel_valid
    frame_windows = 0;
    drive_frame(0, 1'b1, W * H, 3);
    idle(3);
    check_value("count_gaps", frame_windows, 9);

    // Reset on beat (4,6), then a fresh frame without start_of_frame
    frame_windows = 0;
    drive_frame(0, 1'b1, 6 * W + 4, 0);
    reset       = 1'b1;
    pixel_valid = 1'b1;
    pixel_data  = 8'(pix(0, 4, 6));
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    check_value("midreset_valid", int'(wv0), 0);
    check_value("midreset_matrix_nonzero", nonzero_cells(), 0);
    check_value("midreset_type", int'(t0), 0);
    idle(1);
    reset = 1'b0;
    check_value("count_before_reset", frame_windows, 3);
    frame_windows = 0;
    drive_frame(100, 1'b0, W * H, 0);
    idle(3);
    check_value("count_after_reset", frame_windows, 9);

    // start_of_frame coincident with beat (3,4) of a partial frame
    frame_windows = 0;
    drive_frame(50, 1'b1, 4 * W + 3, 0);
    drive_frame(7, 1'b1, W * H, 0);
    idle(3);
    check_value("count_sof_restart", frame_windows, 9);

    idle(2);
    check_value("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
